// File: rtl/execute_stage_md.sv
// execute_stage_md: pipelined MIPS EX stage with two-source forwarding,
// an eight-op ALU, branch-target adder and an iterative multiply/divide
// unit that owns HI/LO and requests stalls while it is busy.
module execute_stage_md #(
    parameter int N        = 32,
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        pc_plus4_E,
    input  logic [N-1:0]        rs_data_E,
    input  logic [N-1:0]        rt_data_E,
    input  logic [N-1:0]        imm_E,
    input  logic [REG_BITS-1:0] rt_E,
    input  logic [REG_BITS-1:0] rd_E,
    input  logic [1:0]          fwdA_E,
    input  logic [1:0]          fwdB_E,
    input  logic [N-1:0]        result_W,
    input  logic [N-1:0]        alu_out_M,
    input  logic [2:0]          alu_ctrl_E,
    input  logic                alu_srcB_E,
    input  logic                reg_dst_E,
    input  logic                md_start_E,
    input  logic [1:0]          md_op_E,
    input  logic [1:0]          md_read_E,
    output logic [N-1:0]        alu_out_E,
    output logic [N-1:0]        write_data_E,
    output logic [N-1:0]        pc_br_E,
    output logic [REG_BITS-1:0] reg_id_E,
    output logic                zero_E,
    output logic                md_stall_E,
    output logic                md_busy
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic {IDLE, RUN} md_state_t;

    md_state_t      state, state_next;

    logic [N-1:0]   src_a, src_b, alu_result;
    logic [N-1:0]   hi, lo;
    logic [CW-1:0]  count;

    // Iterative unit working registers: acc is the running high product
    // half or partial remainder, ops the multiplier or quotient, opb the
    // multiplicand or divisor magnitude.
    logic [N-1:0]   acc, ops, opb;
    logic           is_div, neg_res, neg_rem, div_zero;

    logic           signed_op, a_neg, b_neg;
    logic [N-1:0]   mag_a, mag_b;

    logic [N:0]     mul_sum, div_shift;
    logic [N-1:0]   div_diff;
    logic           div_ge;
    logic [N-1:0]   acc_step, ops_step;
    logic [2*N-1:0] prod_mag, prod_final;
    logic [N-1:0]   quo_final, rem_final;

    // Operand forwarding; the reserved select falls back to the register value.
    always_comb begin
        src_a = rs_data_E;
        case (fwdA_E)
            2'b01:   src_a = result_W;
            2'b10:   src_a = alu_out_M;
            default: src_a = rs_data_E;
        endcase
        write_data_E = rt_data_E;
        case (fwdB_E)
            2'b01:   write_data_E = result_W;
            2'b10:   write_data_E = alu_out_M;
            default: write_data_E = rt_data_E;
        endcase
        src_b = alu_srcB_E ? imm_E : write_data_E;
    end

    // ALU operation select.
    always_comb begin
        alu_result = '0;
        case (alu_ctrl_E)
            3'b000:  alu_result = src_a & src_b;
            3'b001:  alu_result = src_a | src_b;
            3'b010:  alu_result = src_a + src_b;
            3'b011:  alu_result = src_a ^ src_b;
            3'b100:  alu_result = ~(src_a | src_b);
            3'b101:  alu_result = {{(N-1){1'b0}}, (src_a < src_b)};
            3'b110:  alu_result = src_a - src_b;
            default: alu_result = {{(N-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
        endcase
    end

    assign zero_E     = (alu_result == '0);
    assign pc_br_E    = pc_plus4_E + {imm_E[N-3:0], 2'b00};
    assign reg_id_E   = reg_dst_E ? rd_E : rt_E;
    assign md_busy    = (state == RUN);
    assign md_stall_E = md_busy & ((md_read_E != 2'b00) | md_start_E);

    // HI/LO reads override the ALU result on the EX output.
    always_comb begin
        alu_out_E = alu_result;
        case (md_read_E)
            2'b01:   alu_out_E = hi;
            2'b10:   alu_out_E = lo;
            default: alu_out_E = alu_result;
        endcase
    end

    // Operand magnitudes taken at issue; unsigned ops use the raw values.
    always_comb begin
        signed_op = ~md_op_E[0];
        a_neg     = signed_op & src_a[N-1];
        b_neg     = signed_op & src_b[N-1];
        mag_a     = a_neg ? (~src_a + 1'b1) : src_a;
        mag_b     = b_neg ? (~src_b + 1'b1) : src_b;
    end

    // One shift-add or restoring-subtract step, plus sign-corrected results
    // derived from that step so the final iteration can write HI/LO directly.
    always_comb begin
        mul_sum   = {1'b0, acc} + (ops[0] ? {1'b0, opb} : {(N+1){1'b0}});
        div_shift = {acc, ops[N-1]};
        div_ge    = (div_shift >= {1'b0, opb});
        div_diff  = div_shift[N-1:0] - opb;
        if (is_div) begin
            acc_step = div_ge ? div_diff : div_shift[N-1:0];
            ops_step = {ops[N-2:0], div_ge};
        end else begin
            acc_step = mul_sum[N:1];
            ops_step = {mul_sum[0], ops[N-1:1]};
        end
        prod_mag   = {acc_step, ops_step};
        prod_final = neg_res ? (~prod_mag + 1'b1) : prod_mag;
        if (div_zero)
            quo_final = '1;
        else
            quo_final = neg_res ? (~ops_step + 1'b1) : ops_step;
        rem_final  = neg_rem ? (~acc_step + 1'b1) : acc_step;
    end

    // Multiply/divide state register.
    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Next state: leave IDLE on an issue, return after the last step.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (md_start_E) state_next = RUN;
            RUN:     if (count == CW'(1)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Multiply/divide datapath: capture operands at issue, iterate, commit HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi       <= '0;
            lo       <= '0;
            count    <= '0;
            acc      <= '0;
            ops      <= '0;
            opb      <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else if (state == IDLE) begin
            if (md_start_E) begin
                acc      <= '0;
                ops      <= mag_a;
                opb      <= mag_b;
                is_div   <= md_op_E[1];
                neg_res  <= a_neg ^ b_neg;
                neg_rem  <= a_neg;
                div_zero <= (src_b == '0);
                count    <= CW'(N);
            end
        end else begin
            acc   <= acc_step;
            ops   <= ops_step;
            count <= count - CW'(1);
            if (count == CW'(1)) begin
                if (is_div) begin
                    hi <= rem_final;
                    lo <= quo_final;
                end else begin
                    hi <= prod_final[2*N-1:N];
                    lo <= prod_final[N-1:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_execute_stage_md.sv
// tb_execute_stage_md: randomized and directed checks of execute_stage_md at
// N=32 and N=16 against an arithmetic reference model.
module tb_execute_stage_md;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_plus4, rs_data, rt_data, imm, result_W, alu_out_M;
    logic [4:0]  rt, rd;
    logic [1:0]  fwdA, fwdB, md_op, md_read, md_read16;
    logic [2:0]  alu_ctrl;
    logic        alu_srcB, reg_dst, md_start, md_start16;

    logic [31:0] alu_out, write_data, pc_br;
    logic [4:0]  reg_id, reg_id16;
    logic        zero, stall, busy;
    logic [15:0] alu_out16, write_data16, pc_br16;
    logic        zero16, stall16, busy16;

    int compareCount  = 0;
    int mismatchCount = 0;

    execute_stage_md #(.N(32), .REG_BITS(5)) dut32 (
        .clk(clk), .reset(reset), .pc_plus4_E(pc_plus4), .rs_data_E(rs_data),
        .rt_data_E(rt_data), .imm_E(imm), .rt_E(rt), .rd_E(rd), .fwdA_E(fwdA),
        .fwdB_E(fwdB), .result_W(result_W), .alu_out_M(alu_out_M),
        .alu_ctrl_E(alu_ctrl), .alu_srcB_E(alu_srcB), .reg_dst_E(reg_dst),
        .md_start_E(md_start), .md_op_E(md_op), .md_read_E(md_read),
        .alu_out_E(alu_out), .write_data_E(write_data), .pc_br_E(pc_br),
        .reg_id_E(reg_id), .zero_E(zero), .md_stall_E(stall), .md_busy(busy)
    );

    execute_stage_md #(.N(16), .REG_BITS(5)) dut16 (
        .clk(clk), .reset(reset), .pc_plus4_E(pc_plus4[15:0]), .rs_data_E(rs_data[15:0]),
        .rt_data_E(rt_data[15:0]), .imm_E(imm[15:0]), .rt_E(rt), .rd_E(rd), .fwdA_E(fwdA),
        .fwdB_E(fwdB), .result_W(result_W[15:0]), .alu_out_M(alu_out_M[15:0]),
        .alu_ctrl_E(alu_ctrl), .alu_srcB_E(alu_srcB), .reg_dst_E(reg_dst),
        .md_start_E(md_start16), .md_op_E(md_op), .md_read_E(md_read16),
        .alu_out_E(alu_out16), .write_data_E(write_data16), .pc_br_E(pc_br16),
        .reg_id_E(reg_id16), .zero_E(zero16), .md_stall_E(stall16), .md_busy(busy16)
    );

    always #5 clk = ~clk;

    // Count a comparison and report it when the observed value is wrong.
    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compareCount++;
        if (got !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] maskOf(input int w);
        return (64'd1 << w) - 64'd1;
    endfunction

    function automatic longint sx(input logic [63:0] v, input int w);
        return $signed(v << (64 - w)) >>> (64 - w);
    endfunction

    // Reference ALU on w-bit values using plain arithmetic.
    function automatic logic [63:0] aluModel(input logic [2:0] op, input logic [63:0] a_in, b_in, input int w);
        logic [63:0] a, b, r;
        a = a_in & maskOf(w);
        b = b_in & maskOf(w);
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = a + b;
            3'd3: r = a ^ b;
            3'd4: r = ~(a | b);
            3'd5: r = (a < b) ? 64'd1 : 64'd0;
            3'd6: r = a - b;
            default: r = (sx(a, w) < sx(b, w)) ? 64'd1 : 64'd0;
        endcase
        return r & maskOf(w);
    endfunction

    // Reference multiply/divide: full-width product, truncating division.
    task automatic mdModel(input logic [1:0] op, input logic [63:0] a_in, b_in, input int w,
                           output logic [63:0] hi, output logic [63:0] lo);
        logic [63:0] mask, a, b, p;
        longint sa, sb;
        mask = maskOf(w);
        a = a_in & mask;
        b = b_in & mask;
        sa = sx(a, w);
        sb = sx(b, w);
        if (!op[1]) begin
            if (op[0]) p = a * b;
            else       p = 64'(sa * sb);
            lo = p & mask;
            hi = (p >> w) & mask;
        end else if (b == 64'd0) begin
            hi = a;
            lo = mask;
        end else if (op[0]) begin
            lo = (a / b) & mask;
            hi = (a % b) & mask;
        end else begin
            lo = 64'(sa / sb) & mask;
            hi = 64'(sa % sb) & mask;
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a_reg, b_reg, immv, wb, mem, pc,
                                 input logic [1:0] fa, fb, input logic [2:0] op,
                                 input logic sb, rdst, input logic [4:0] rtv, rdv);
        @(negedge clk);
        rs_data = a_reg; rt_data = b_reg; imm = immv; result_W = wb; alu_out_M = mem;
        pc_plus4 = pc; fwdA = fa; fwdB = fb; alu_ctrl = op; alu_srcB = sb;
        reg_dst = rdst; rt = rtv; rd = rdv;
        #1;
    endtask

    // Compare the combinational EX outputs of both widths with the model.
    task automatic checkAlu(input string tag);
        logic [63:0] a, fb, b, res32, res16, pcb;
        a  = (fwdA == 2'b01) ? {32'h0, result_W} : (fwdA == 2'b10) ? {32'h0, alu_out_M} : {32'h0, rs_data};
        fb = (fwdB == 2'b01) ? {32'h0, result_W} : (fwdB == 2'b10) ? {32'h0, alu_out_M} : {32'h0, rt_data};
        b  = alu_srcB ? {32'h0, imm} : fb;
        res32 = aluModel(alu_ctrl, a, b, 32);
        res16 = aluModel(alu_ctrl, a, b, 16);
        pcb   = {32'h0, pc_plus4} + ({32'h0, imm} << 2);
        checkOutput({tag, "_alu32"}, {32'h0, alu_out}, res32);
        checkOutput({tag, "_zero32"}, {63'h0, zero}, {63'h0, (res32 == 64'd0)});
        checkOutput({tag, "_wdata32"}, {32'h0, write_data}, fb);
        checkOutput({tag, "_pcbr32"}, {32'h0, pc_br}, pcb & maskOf(32));
        checkOutput({tag, "_regid"}, {59'h0, reg_id}, {59'h0, (reg_dst ? rd : rt)});
        checkOutput({tag, "_alu16"}, {48'h0, alu_out16}, res16);
        checkOutput({tag, "_zero16"}, {63'h0, zero16}, {63'h0, (res16 == 64'd0)});
        checkOutput({tag, "_wdata16"}, {48'h0, write_data16}, fb & maskOf(16));
        checkOutput({tag, "_pcbr16"}, {48'h0, pc_br16}, pcb & maskOf(16));
    endtask

    function automatic logic curStall(input bit use16);
        return use16 ? stall16 : stall;
    endfunction

    function automatic logic curBusy(input bit use16);
        return use16 ? busy16 : busy;
    endfunction

    function automatic logic [63:0] curAlu(input bit use16);
        return use16 ? {48'h0, alu_out16} : {32'h0, alu_out};
    endfunction

    task automatic setMd(input bit use16, input logic start, input logic [1:0] rd_sel);
        if (use16) begin
            md_start16 = start; md_read16 = rd_sel;
        end else begin
            md_start = start; md_read = rd_sel;
        end
    endtask

    task automatic loadMdOperands(input logic [1:0] op, input logic [31:0] a, b);
        rs_data = a; rt_data = b; fwdA = 2'b00; fwdB = 2'b00; alu_srcB = 1'b0; md_op = op;
    endtask

    // Count stalled cycles of a held read/start, bounded so a stuck unit still ends.
    task automatic countStall(input bit use16, output int cnt);
        cnt = 0;
        #1;
        while (curStall(use16) && cnt < 200) begin
            cnt++;
            @(negedge clk);
            #1;
        end
    endtask

    // Issue one MD op, hold mflo in EX until the stall drops, then read HI/LO.
    task automatic runMd(input bit use16, input logic [1:0] op, input logic [31:0] a, b);
        logic [63:0] ehi, elo;
        int w, cnt;
        w = use16 ? 16 : 32;
        mdModel(op, {32'h0, a}, {32'h0, b}, w, ehi, elo);
        @(negedge clk);
        loadMdOperands(op, a, b);
        setMd(use16, 1'b1, 2'b00);
        #1;
        checkOutput("md_issue_nostall", {63'h0, curStall(use16)}, 64'd0);
        @(negedge clk);
        setMd(use16, 1'b0, 2'b10);
        countStall(use16, cnt);
        checkOutput("md_stall_cycles", 64'(cnt), 64'(w));
        checkOutput("md_busy_done", {63'h0, curBusy(use16)}, 64'd0);
        checkOutput("md_lo", curAlu(use16), elo);
        setMd(use16, 1'b0, 2'b01);
        #1;
        checkOutput("md_hi", curAlu(use16), ehi);
        setMd(use16, 1'b0, 2'b00);
    endtask

    // Reset ten cycles into a multu, then confirm a clean restart.
    task automatic resetMidOp(input bit use16);
        @(negedge clk);
        loadMdOperands(2'b01, $urandom, $urandom);
        setMd(use16, 1'b1, 2'b00);
        @(negedge clk);
        setMd(use16, 1'b0, 2'b00);
        repeat (9) @(negedge clk);
        #1;
        checkOutput("rst_busy_before", {63'h0, curBusy(use16)}, 64'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rst_busy_after", {63'h0, curBusy(use16)}, 64'd0);
        setMd(use16, 1'b0, 2'b01);
        #1;
        checkOutput("rst_hi", curAlu(use16), 64'd0);
        setMd(use16, 1'b0, 2'b10);
        #1;
        checkOutput("rst_lo", curAlu(use16), 64'd0);
        setMd(use16, 1'b0, 2'b00);
        runMd(use16, 2'($urandom_range(0, 3)), $urandom, $urandom);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] h1, l1, h2, l2, hi_e, lo_e;
        int cnt;
        reset = 1'b1;
        pc_plus4 = '0; rs_data = '0; rt_data = '0; imm = '0; result_W = '0; alu_out_M = '0;
        rt = '0; rd = '0; fwdA = '0; fwdB = '0; alu_ctrl = '0; alu_srcB = 1'b0; reg_dst = 1'b0;
        md_start = 1'b0; md_start16 = 1'b0; md_op = '0; md_read = '0; md_read16 = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("reset_busy32", {63'h0, busy}, 64'd0);
        checkOutput("reset_busy16", {63'h0, busy16}, 64'd0);
        md_read = 2'b01; md_read16 = 2'b01;
        #1;
        checkOutput("reset_hi32", {32'h0, alu_out}, 64'd0);
        checkOutput("reset_hi16", {48'h0, alu_out16}, 64'd0);
        md_read = 2'b10; md_read16 = 2'b10;
        #1;
        checkOutput("reset_lo32", {32'h0, alu_out}, 64'd0);
        md_read = 2'b00; md_read16 = 2'b00;

        // Directed ALU, forwarding and branch cases.
        applyStimulus(32'd5, 32'd0, 32'd1, 32'd0, 32'd9, 32'd0, 2'b10, 2'b00, 3'b010, 1'b1, 1'b0, 5'd3, 5'd7);
        checkOutput("fwd_add", {32'h0, alu_out}, 64'd10);
        checkOutput("fwd_add_zero", {63'h0, zero}, 64'd0);
        checkAlu("fwd");
        applyStimulus(32'h1234, 32'h1234, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 3'b110, 1'b0, 1'b1, 5'd3, 5'd7);
        checkOutput("sub_zero", {63'h0, zero}, 64'd1);
        applyStimulus(32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 3'b111, 1'b0, 1'b0, 5'd1, 5'd2);
        checkOutput("slt_neg", {32'h0, alu_out}, 64'd1);
        applyStimulus(32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 3'b101, 1'b0, 1'b0, 5'd1, 5'd2);
        checkOutput("sltu_big", {32'h0, alu_out}, 64'd0);
        applyStimulus(32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'h1000, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0, 5'd1, 5'd2);
        checkOutput("branch_back", {32'h0, pc_br}, 64'h0000_0FFC);

        // Randomized ALU/forwarding sweep on both widths.
        for (int i = 0; i < 30; i++) begin
            applyStimulus($urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
                          2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom), 5'($urandom));
            checkAlu("rand");
        end

        // Directed multiply/divide cases.
        runMd(1'b0, 2'b00, 32'hFFFF_FFFD, 32'd7);
        mdModel(2'b00, 64'hFFFF_FFFD, 64'd7, 32, hi_e, lo_e);
        checkOutput("mult_neg_lo_const", lo_e, 64'hFFFF_FFEB);
        runMd(1'b0, 2'b11, 32'd100, 32'd7);
        runMd(1'b0, 2'b10, 32'hFFFF_FFF9, 32'd2);
        runMd(1'b0, 2'b10, 32'd5, 32'd0);
        runMd(1'b0, 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);

        // Randomized multiply/divide at N=32 and N=16.
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a, b;
            a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            runMd(1'b0, 2'($urandom_range(0, 3)), a, b);
        end
        for (int i = 0; i < 5; i++) begin
            logic [31:0] a, b;
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            runMd(1'b1, 2'($urandom_range(0, 3)), a, b);
        end

        // Back-to-back issue: second start waits, read alongside it sees old HI/LO.
        @(negedge clk);
        loadMdOperands(2'b00, 32'd1234567, 32'd89);
        mdModel(2'b00, 64'd1234567, 64'd89, 32, h1, l1);
        md_start = 1'b1; md_read = 2'b00;
        @(negedge clk);
        loadMdOperands(2'b11, 32'd1000003, 32'd97);
        mdModel(2'b11, 64'd1000003, 64'd97, 32, h2, l2);
        md_read = 2'b10;
        countStall(1'b0, cnt);
        checkOutput("b2b_wait_cycles", 64'(cnt), 64'd32);
        checkOutput("b2b_prestart_lo", {32'h0, alu_out}, l1);
        @(negedge clk);
        md_start = 1'b0;
        countStall(1'b0, cnt);
        checkOutput("b2b_second_cycles", 64'(cnt), 64'd32);
        checkOutput("b2b_second_lo", {32'h0, alu_out}, l2);
        md_read = 2'b01;
        #1;
        checkOutput("b2b_second_hi", {32'h0, alu_out}, h2);
        md_read = 2'b00;

        // Independent ALU instruction while the unit is busy does not stall.
        @(negedge clk);
        loadMdOperands(2'b00, 32'hFFFF_FFF0, 32'h10);
        mdModel(2'b00, 64'hFFFF_FFF0, 64'h10, 32, h1, l1);
        md_start = 1'b1;
        applyStimulus(32'd40, 32'd2, 32'd0, 32'd0, 32'd0, 32'h400, 2'b00, 2'b00, 3'b110, 1'b0, 1'b1, 5'd4, 5'd9);
        md_start = 1'b0;
        #1;
        checkOutput("indep_nostall", {63'h0, stall}, 64'd0);
        checkOutput("indep_busy", {63'h0, busy}, 64'd1);
        checkAlu("indep");
        @(negedge clk);
        md_read = 2'b10;
        countStall(1'b0, cnt);
        checkOutput("indep_rest_cycles", 64'(cnt), 64'd31);
        checkOutput("indep_lo", {32'h0, alu_out}, l1);
        md_read = 2'b00;

        // Reset during an operation at both widths.
        resetMidOp(1'b0);
        resetMidOp(1'b1);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule

// File: doc/execute_stage_md.md
# execute_stage_md

Parametrised execute stage for the pipelined MIPS core. It generalises the single-cycle EX datapath with configurable datapath width, two-source operand forwarding, a wider ALU op set, and an iterative multiply/divide unit owning the HI/LO registers. While a multiply/divide is in flight the unit raises a stall request toward the hazard unit. It sits between the ID/EX and EX/MEM pipeline registers.

## Interface
Parameters:
- N, 32, datapath width (N ≥ 8, even)
- REG_BITS, 5, register-index width

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- pc_plus4_E  in  N  PC+4 of the instruction in EX
- rs_data_E, rt_data_E  in  N  register-file read values
- imm_E  in  N  sign-extended immediate
- rt_E, rd_E  in  REG_BITS  destination candidates
- fwdA_E, fwdB_E  in  2  forward select: 00 reg value, 01 result_W, 10 alu_out_M, 11 reserved (treat as 00)
- result_W, alu_out_M  in  N  forwarded values from WB / MEM
- alu_ctrl_E  in  3  ALU op
- alu_srcB_E  in  1  0: forwarded B, 1: imm_E
- reg_dst_E  in  1  0: rt_E, 1: rd_E
- md_start_E  in  1  issue multiply/divide
- md_op_E  in  2  00 mult, 01 multu, 10 div, 11 divu
- md_read_E  in  2  00 none, 01 mfhi, 10 mflo, 11 reserved (none)
- alu_out_E  out  N  ALU result, or HI/LO when md_read_E selects
- write_data_E  out  N  forwarded B operand (store data)
- pc_br_E  out  N  branch target
- reg_id_E  out  REG_BITS  destination register
- zero_E  out  1  ALU result == 0
- md_stall_E  out  1  stall request to hazard unit
- md_busy  out  1  multiply/divide in progress

## Operation
- srcA = fwdA mux; fwdB mux output drives write_data_E; srcB = alu_srcB_E ? imm_E : write_data_E.
- ALU ops: 000 AND, 001 OR, 010 ADD, 011 XOR, 100 NOR, 101 SLTU, 110 SUB, 111 SLT (signed). Add/sub wrap modulo 2^N; SLT/SLTU give 1 or 0 zero-extended.
- zero_E reflects the ALU result only, never the HI/LO read.
- pc_br_E = pc_plus4_E + {imm_E[N-3:0], 2'b00}, modulo 2^N.
- alu_out_E = HI when md_read_E=01, LO when 10, else ALU result. Combinational.
- MD FSM, states IDLE and RUN:
  - IDLE + md_start_E: latch |srcA|, |srcB| (signed ops), record result signs, counter=N, go to RUN. md_busy=1.
  - RUN: one shift-add (mult) or restoring-subtract (div) step per cycle; counter decrements.
  - On the last step (counter=1), write HI/LO with sign correction and return to IDLE.
- Mult: {HI,LO} = 2N-bit product.
- Div: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- Divide by zero: HI = dividend as given, LO = all ones; normal N-cycle latency.
- md_read_E with md_start_E in the same cycle: the read returns the pre-start HI/LO.

## Timing
- Reset: md_busy=0, state IDLE, HI=LO=0, counter=0. Combinational outputs follow their inputs.
- Reset mid-operation aborts the operation; HI=LO=0 after the edge.
- Start accepted at edge T (IDLE). md_busy is high for cycles T+1 .. T+N. HI/LO are updated at edge T+N, and md_busy=0 in cycle T+N+1.
- md_stall_E = md_busy & (md_read_E≠00 | md_start_E). Combinational; it holds the EX instruction.
- The first stall-free mfhi/mflo sees the new HI/LO.
- md_start_E while busy is not accepted; it is stalled and accepted on the first edge with md_busy=0.
- An independent non-MD instruction does not stall while md_busy is high.

## Test plan
- Forwarding, N=32: rs_data=5, alu_out_M=9, fwdA=10, imm=1, alu_srcB=1, ADD -> alu_out_E=10, zero_E=0. SUB with A=B -> zero_E=1.
- SLT vs SLTU with A=0xFFFFFFFF, B=1 -> 1 and 0. Branch: pc_plus4=0x1000, imm=0xFFFFFFFF -> pc_br_E=0x00000FFC.
- mult A=0xFFFFFFFD (-3), B=7, then mflo held in EX -> md_stall_E high for exactly 32 cycles. Then LO=0xFFFFFFEB, HI=0xFFFFFFFF.
- divu 100/7 -> LO=14, HI=2. div -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. div 5/0 -> HI=5, LO=0xFFFFFFFF.
- Back-to-back starts: second start stalls until md_busy falls, then completes N cycles later. Assert md_stall_E only while the second start is waiting.
- reset asserted 10 cycles into a multu -> next cycle md_busy=0, HI=LO=0. A new start then completes normally. Repeat at N=16.
